// File: rtl/rf_access_sequencer_if.sv
// Bundle of the request, selector, BRAM and response signals of rf_access_sequencer.
// slave is the sequencer's view; master is the surrounding system (selector, BRAMs, requester).
interface rf_access_sequencer_if #(
   parameter int NUM_BRAMS = 4,
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 6
);
   localparam int RD_LANES = NUM_BRAMS * 2;

   logic                                req_valid;
   logic                                req_ready;
   logic [11:0]                         req_r_mask;
   logic [11:0][ADDR_W-1:0]             req_r_addr;
   logic [5:0]                          req_w_mask;
   logic [5:0][ADDR_W-1:0]              req_w_addr;
   logic [5:0][DATA_W-1:0]              req_w_data;

   logic [11:0]                         r_read_mask;
   logic [11:0]                         r_done_mask;
   logic [5:0]                          w_read_mask;
   logic [5:0]                          w_done_mask;
   logic [RD_LANES-1:0][3:0]            r_selected_id;
   logic [1:0][2:0]                     w_selected_id;

   logic [RD_LANES-1:0]                 bram_rd_en;
   logic [RD_LANES-1:0][ADDR_W-1:0]     bram_rd_addr;
   logic [RD_LANES-1:0][DATA_W-1:0]     bram_rd_data;
   logic [1:0]                          bram_wr_en;
   logic [1:0][ADDR_W-1:0]              bram_wr_addr;
   logic [1:0][DATA_W-1:0]              bram_wr_data;

   logic                                rsp_valid;
   logic                                rsp_ready;
   logic [11:0][DATA_W-1:0]             rsp_r_data;

   modport slave (
      input  req_valid, req_r_mask, req_r_addr, req_w_mask, req_w_addr, req_w_data,
      input  r_selected_id, w_selected_id, bram_rd_data, rsp_ready,
      output req_ready, r_read_mask, r_done_mask, w_read_mask, w_done_mask,
      output bram_rd_en, bram_rd_addr, bram_wr_en, bram_wr_addr, bram_wr_data,
      output rsp_valid, rsp_r_data
   );

   modport master (
      output req_valid, req_r_mask, req_r_addr, req_w_mask, req_w_addr, req_w_data,
      output r_selected_id, w_selected_id, bram_rd_data, rsp_ready,
      input  req_ready, r_read_mask, r_done_mask, w_read_mask, w_done_mask,
      input  bram_rd_en, bram_rd_addr, bram_wr_en, bram_wr_addr, bram_wr_data,
      input  rsp_valid, rsp_r_data
   );
endinterface

// File: rtl/rf_access_sequencer.sv
// Batch register-file access controller: issues selector-chosen reads then writes, returns read batch.
// Optional macro RF_SEQ_X0_EN makes register 0 a hardwired zero (never read or written in BRAM).
module rf_access_sequencer #(
   parameter int NUM_BRAMS = 4,
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   rf_access_sequencer_if.slave  bus
);
   localparam int RD_LANES = NUM_BRAMS * 2;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   logic [1:0]                      state;
   logic [11:0]                     r_mask_q;
   logic [11:0]                     r_done_q;
   logic [11:0][ADDR_W-1:0]         r_addr_q;
   logic [5:0]                      w_mask_q;
   logic [5:0]                      w_done_q;
   logic [5:0][ADDR_W-1:0]          w_addr_q;
   logic [5:0][DATA_W-1:0]          w_data_q;
   logic [11:0][DATA_W-1:0]         rsp_data_q;
   logic [RD_LANES-1:0]             pipe_vld_q;
   logic [RD_LANES-1:0][3:0]        pipe_id_q;

   logic [11:0]                     r_pend;
   logic [11:0]                     r_issue;
   logic [11:0]                     r_preset;
   logic [5:0]                      w_pend;
   logic [5:0]                      w_issue;
   logic [5:0]                      w_preset;
   logic [3:0]                      r_cnt;
   logic [2:0]                      w_cnt;
   logic [RD_LANES-1:0]             rd_use;
   logic [1:0]                      wr_use;
   logic [1:0][ADDR_W-1:0]          wr_addr;
   logic [1:0][DATA_W-1:0]          wr_data;

   // Pending sets, lane usage and the ID sets issued this cycle.
   always_comb begin
      r_pend = r_mask_q & ~r_done_q;
      w_pend = w_mask_q & ~w_done_q;
      r_cnt = '0;
      for (int i = 0; i < 12; i++) r_cnt = r_cnt + 4'(r_pend[i]);
      w_cnt = '0;
      for (int i = 0; i < 6; i++) w_cnt = w_cnt + 3'(w_pend[i]);
      r_issue = '0;
      for (int k = 0; k < RD_LANES; k++) begin
         rd_use[k] = (state == READ) && (k < int'(r_cnt)) && (bus.r_selected_id[k] < 4'd12);
         if (rd_use[k]) r_issue[bus.r_selected_id[k]] = 1'b1;
      end
      w_issue = '0;
      for (int j = 0; j < 2; j++) begin
         wr_use[j]  = (state == WRITE) && (j < int'(w_cnt)) && (bus.w_selected_id[j] < 3'd6);
         wr_addr[j] = '0;
         wr_data[j] = '0;
         if (wr_use[j]) begin
            w_issue[bus.w_selected_id[j]] = 1'b1;
            wr_addr[j] = w_addr_q[bus.w_selected_id[j]];
            wr_data[j] = w_data_q[bus.w_selected_id[j]];
         end
      end
   end

   // Requests that are complete at accept time without touching a BRAM.
   always_comb begin
      r_preset = '0;
      w_preset = '0;
`ifdef RF_SEQ_X0_EN
      for (int i = 0; i < 12; i++) r_preset[i] = bus.req_r_mask[i] && (bus.req_r_addr[i] == '0);
      for (int i = 0; i < 6; i++)  w_preset[i] = bus.req_w_mask[i] && (bus.req_w_addr[i] == '0);
`endif
   end

   // BRAM port drive; when both write lanes hit one register the higher ID (lane 1) wins.
   always_comb begin
      for (int k = 0; k < RD_LANES; k++) begin
         bus.bram_rd_en[k]   = rd_use[k];
         bus.bram_rd_addr[k] = rd_use[k] ? r_addr_q[bus.r_selected_id[k]] : '0;
      end
      bus.bram_wr_en[1]   = wr_use[1];
      bus.bram_wr_en[0]   = wr_use[0] && !(wr_use[1] && (wr_addr[0] == wr_addr[1]));
      bus.bram_wr_addr    = wr_addr;
      bus.bram_wr_data    = wr_data;
   end

   assign bus.req_ready   = (state == IDLE);
   assign bus.rsp_valid   = (state == RESP);
   assign bus.rsp_r_data  = rsp_data_q;
   assign bus.r_read_mask = r_mask_q;
   assign bus.r_done_mask = r_done_q;
   assign bus.w_read_mask = w_mask_q;
   assign bus.w_done_mask = w_done_q;

   // Batch FSM plus the one-cycle read pipeline that lands BRAM data in its response slot.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         r_mask_q   <= '0;
         r_done_q   <= '0;
         r_addr_q   <= '0;
         w_mask_q   <= '0;
         w_done_q   <= '0;
         w_addr_q   <= '0;
         w_data_q   <= '0;
         rsp_data_q <= '0;
         pipe_vld_q <= '0;
         pipe_id_q  <= '0;
      end else begin
         pipe_vld_q <= rd_use;
         pipe_id_q  <= bus.r_selected_id;
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  r_mask_q   <= bus.req_r_mask;
                  r_addr_q   <= bus.req_r_addr;
                  w_mask_q   <= bus.req_w_mask;
                  w_addr_q   <= bus.req_w_addr;
                  w_data_q   <= bus.req_w_data;
                  r_done_q   <= r_preset;
                  w_done_q   <= w_preset;
                  rsp_data_q <= '0;
                  state      <= ((bus.req_r_mask & ~r_preset) != '0) ? READ : WRITE;
               end
            end
            READ: begin
               r_done_q <= r_done_q | r_issue;
               if ((r_pend & ~r_issue) == '0) state <= WRITE;
            end
            WRITE: begin
               w_done_q <= w_done_q | w_issue;
               if ((w_pend & ~w_issue) == '0) state <= RESP;
            end
            default: begin
               if (bus.rsp_ready) begin
                  state    <= IDLE;
                  r_mask_q <= '0;
                  r_done_q <= '0;
                  w_mask_q <= '0;
                  w_done_q <= '0;
               end
            end
         endcase
         for (int k = 0; k < RD_LANES; k++)
            if (pipe_vld_q[k]) rsp_data_q[pipe_id_q[k]] <= bus.bram_rd_data[k];
      end
   end
endmodule

// File: tb/tb_rf_access_sequencer.sv
// Randomized scoreboard bench for rf_access_sequencer with selector and BRAM models.
`timescale 1ns/1ps
module tb_rf_access_sequencer;
   localparam int NB = 4;
   localparam int DW = 32;
   localparam int AW = 6;
   localparam int RL = NB * 2;
`ifdef RF_SEQ_X0_EN
   localparam bit X0 = 1'b1;
`else
   localparam bit X0 = 1'b0;
`endif

   typedef struct {
      logic [11:0][DW-1:0] data;
      int                  acc;
      int                  lat;
   } exp_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic preload_req = 1'b1;
   int cyc = 0;
   int compared = 0;
   int mismatched = 0;
   int bp_req_count = 0;
   bit prev_valid = 1'b0;
   bit expect_idle = 1'b0;
   logic [DW-1:0] bram [64];
   logic [DW-1:0] ref_mem [64];
   exp_t sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   rf_access_sequencer_if #(.NUM_BRAMS(NB), .DATA_W(DW), .ADDR_W(AW)) bus();
   rf_access_sequencer #(.NUM_BRAMS(NB), .DATA_W(DW), .ADDR_W(AW)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   // Selector stand-in: pending IDs handed out in ascending order, one per lane.
   always_comb begin
      int n;
      n = 0;
      bus.r_selected_id = '0;
      for (int i = 0; i < 12; i++)
         if (bus.r_read_mask[i] && !bus.r_done_mask[i]) begin
            if (n < RL) bus.r_selected_id[n] = 4'(i);
            n++;
         end
   end

   always_comb begin
      int n;
      n = 0;
      bus.w_selected_id = '0;
      for (int i = 0; i < 6; i++)
         if (bus.w_read_mask[i] && !bus.w_done_mask[i]) begin
            if (n < 2) bus.w_selected_id[n] = 3'(i);
            n++;
         end
   end

   // Register-file BRAM with 1-cycle read latency; all replicas hold the same contents.
   always @(posedge clk) begin
      if (preload_req) begin
         for (int a = 0; a < 64; a++) bram[a] <= ref_mem[a];
      end else begin
         for (int k = 0; k < RL; k++)
            if (bus.bram_rd_en[k]) bus.bram_rd_data[k] <= bram[bus.bram_rd_addr[k]];
         for (int j = 0; j < 2; j++)
            if (bus.bram_wr_en[j]) bram[bus.bram_wr_addr[j]] <= bus.bram_wr_data[j];
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic bit live(input logic [AW-1:0] a);
      return (a != '0) || !X0;
   endfunction

   // Response acceptor: occasional random stalls, or a forced 5-cycle stall on request.
   initial begin
      int bp_served;
      int bp_cnt;
      bp_served = 0;
      bp_cnt = 0;
      bus.rsp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (bp_req_count != bp_served) begin
            bp_served = bp_req_count;
            bp_cnt = 5;
         end
         if (bp_cnt > 0) begin
            bus.rsp_ready = 1'b0;
            if (bus.rsp_valid) bp_cnt--;
         end else begin
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
         end
      end
   end

   // Monitor: compares every presented response cycle against the scoreboard head.
   always @(negedge clk) begin
      if (expect_idle) begin
         checkOutput("req_ready_after_handshake", 64'(bus.req_ready), 64'd1);
         expect_idle = 1'b0;
      end
      if (reset && bus.rsp_valid) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_rsp_valid", 64'd1, 64'd0);
         end else begin
            if (!prev_valid) checkOutput("rsp_latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
            checkOutput("req_ready_in_resp", 64'(bus.req_ready), 64'd0);
            for (int i = 0; i < 12; i++)
               checkOutput($sformatf("rsp_slot%0d", i), 64'(bus.rsp_r_data[i]), 64'(sb[0].data[i]));
            if (bus.rsp_ready) begin
               void'(sb.pop_front());
               expect_idle = 1'b1;
            end
         end
      end
      prev_valid = bus.rsp_valid;
   end

   // Offer one batch, predict its response and per-cycle BRAM traffic, wait until back in idle.
   task automatic applyStimulus(input logic [11:0] rm, input logic [11:0][AW-1:0] ra,
                                input logic [5:0] wm, input logic [5:0][AW-1:0] wa,
                                input logic [5:0][DW-1:0] wd);
      exp_t e;
      int rid[$];
      int wid[$];
      int nr, nw, R, W, t;
      for (int i = 0; i < 12; i++) if (rm[i] && live(ra[i])) rid.push_back(i);
      for (int i = 0; i < 6; i++)  if (wm[i] && live(wa[i])) wid.push_back(i);
      nr = rid.size();
      nw = wid.size();
      R = (nr + RL - 1) / RL;
      W = (nw == 0) ? 1 : (nw + 1) / 2;
      for (int i = 0; i < 12; i++) e.data[i] = (rm[i] && live(ra[i])) ? ref_mem[ra[i]] : '0;
      foreach (wid[i]) ref_mem[wa[wid[i]]] = wd[wid[i]];
      e.lat = R + W + 1;

      bus.req_r_mask = rm;
      bus.req_r_addr = ra;
      bus.req_w_mask = wm;
      bus.req_w_addr = wa;
      bus.req_w_data = wd;
      bus.req_valid  = 1'b1;
      t = 0;
      while (!bus.req_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!bus.req_ready) begin
         checkOutput("accept_timeout", 64'd0, 64'd1);
         bus.req_valid = 1'b0;
         return;
      end
      e.acc = cyc;
      sb.push_back(e);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;

      for (int c = 1; c <= R + W; c++) begin
         logic [RL-1:0] er;
         logic [1:0] ew;
         int base;
         @(negedge clk);
         er = '0;
         ew = '0;
         if (c <= R) begin
            base = (c - 1) * RL;
            for (int k = 0; k < RL; k++) er[k] = (base + k < nr);
            checkOutput("rd_en", 64'(bus.bram_rd_en), 64'(er));
            checkOutput("wr_en_during_read", 64'(bus.bram_wr_en), 64'd0);
            for (int k = 0; k < RL; k++)
               if (er[k]) checkOutput($sformatf("rd_addr_lane%0d", k),
                                      64'(bus.bram_rd_addr[k]), 64'(ra[rid[base + k]]));
         end else begin
            base = (c - R - 1) * 2;
            ew[0] = (base < nw);
            ew[1] = (base + 1 < nw);
            if (ew[1] && wa[wid[base]] == wa[wid[base + 1]]) ew[0] = 1'b0;
            checkOutput("wr_en", 64'(bus.bram_wr_en), 64'(ew));
            checkOutput("rd_en_during_write", 64'(bus.bram_rd_en), 64'd0);
            for (int j = 0; j < 2; j++)
               if (ew[j]) begin
                  checkOutput($sformatf("wr_addr_lane%0d", j), 64'(bus.bram_wr_addr[j]), 64'(wa[wid[base + j]]));
                  checkOutput($sformatf("wr_data_lane%0d", j), 64'(bus.bram_wr_data[j]), 64'(wd[wid[base + j]]));
               end
         end
      end

      t = 0;
      while (!bus.req_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      if (!bus.req_ready) checkOutput("rsp_timeout", 64'd0, 64'd1);
   endtask

   // Offer a full read batch and pull reset low during its first READ cycle.
   task automatic applyReset();
      int t;
      bus.req_r_mask = 12'hFFF;
      for (int i = 0; i < 12; i++) bus.req_r_addr[i] = AW'($urandom_range(1, 63));
      bus.req_w_mask = '0;
      bus.req_valid  = 1'b1;
      t = 0;
      while (!bus.req_ready && t < 200) begin
         @(negedge clk);
         t++;
      end
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      checkOutput("rst_pre_rd_en", 64'(bus.bram_rd_en), 64'({RL{1'b1}}));
      reset = 1'b0;
      #1;
      checkOutput("rst_rd_en_drop", 64'(bus.bram_rd_en), 64'd0);
      checkOutput("rst_wr_en_drop", 64'(bus.bram_wr_en), 64'd0);
      checkOutput("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      checkOutput("rst_r_read_mask", 64'(bus.r_read_mask), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("rst_req_ready_after", 64'(bus.req_ready), 64'd1);
      checkOutput("rst_rd_en_after", 64'(bus.bram_rd_en), 64'd0);
   endtask

   initial begin
      logic [11:0]          rm;
      logic [11:0][AW-1:0]  ra;
      logic [5:0]           wm;
      logic [5:0][AW-1:0]   wa;
      logic [5:0][DW-1:0]   wd;
      bus.req_valid  = 1'b0;
      bus.req_r_mask = '0;
      bus.req_r_addr = '0;
      bus.req_w_mask = '0;
      bus.req_w_addr = '0;
      bus.req_w_data = '0;
      for (int a = 0; a < 64; a++) ref_mem[a] = $urandom();
      repeat (2) @(negedge clk);
      checkOutput("reset_req_ready", 64'(bus.req_ready), 64'd1);
      checkOutput("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      checkOutput("reset_rd_en", 64'(bus.bram_rd_en), 64'd0);
      checkOutput("reset_wr_en", 64'(bus.bram_wr_en), 64'd0);
      checkOutput("reset_masks", 64'({bus.r_read_mask, bus.r_done_mask, bus.w_read_mask, bus.w_done_mask}), 64'd0);
      checkOutput("reset_rsp_data", 64'(|bus.rsp_r_data), 64'd0);
      preload_req = 1'b0;
      reset = 1'b1;
      @(negedge clk);

      // Full batch: 12 reads, 3 writes.
      rm = 12'hFFF;
      for (int i = 0; i < 12; i++) ra[i] = AW'($urandom_range(1, 63));
      wm = 6'b000111;
      for (int i = 0; i < 6; i++) begin
         wa[i] = AW'($urandom_range(1, 63));
         wd[i] = $urandom();
      end
      wa[1] = 6'd20;
      wa[2] = 6'd21;
      wa[0] = 6'd22;
      applyStimulus(rm, ra, wm, wa, wd);

      // Read-before-write on r5, then read back.
      rm = 12'h001; ra = '0; ra[0] = 6'd5;
      wm = 6'b000001; wa = '0; wa[0] = 6'd5; wd = '0; wd[0] = 32'hDEAD;
      applyStimulus(rm, ra, wm, wa, wd);
      wm = '0;
      applyStimulus(rm, ra, wm, wa, wd);

      // Sparse read mask, no writes.
      rm = 12'h801; ra = '0; ra[0] = 6'd3; ra[11] = 6'd40;
      applyStimulus(rm, ra, wm, wa, wd);

      // Empty batch.
      applyStimulus(12'h000, ra, 6'h00, wa, wd);

      // Backpressure on the response.
      bp_req_count++;
      rm = 12'h0F0;
      for (int i = 0; i < 12; i++) ra[i] = AW'($urandom_range(1, 63));
      applyStimulus(rm, ra, wm, wa, wd);

      // Same-address writes in one cycle, then read back.
      wm = 6'b000011; wa = '0; wa[0] = 6'd9; wa[1] = 6'd9;
      wd[0] = 32'h1111_1111; wd[1] = 32'h2222_2222;
      applyStimulus(12'h000, ra, wm, wa, wd);
      rm = 12'h004; ra = '0; ra[2] = 6'd9;
      applyStimulus(rm, ra, 6'h00, wa, wd);

      // Register 0 traffic.
      rm = 12'h001; ra = '0;
      wm = 6'b000001; wa = '0; wd = '0; wd[0] = 32'd7;
      applyStimulus(rm, ra, wm, wa, wd);
      applyStimulus(rm, ra, 6'h00, wa, wd);

      applyReset();

      // Random batches over a small address range to provoke collisions.
      for (int b = 0; b < 150; b++) begin
         rm = 12'($urandom());
         wm = 6'($urandom());
         for (int i = 0; i < 12; i++) ra[i] = AW'($urandom_range(0, 15));
         for (int i = 0; i < 6; i++) begin
            wa[i] = AW'($urandom_range(0, 15));
            wd[i] = $urandom();
         end
         if (b % 17 == 0) bp_req_count++;
         applyStimulus(rm, ra, wm, wa, wd);
      end

      repeat (3) @(negedge clk);
      checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      mismatched++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $fatal(1, "[TB] watchdog expired");
   end
endmodule

// File: doc/rf_access_sequencer.md
# rf_access_sequencer

Batch register-file access controller that sits directly downstream of `rf_selector_module` and drives the replicated register-file BRAMs. It latches one batch of up to 12 read and 6 write requests, publishes pending/done masks to the selector, and issues the selector's chosen IDs to the BRAM ports. It then collects read data and returns the complete read batch through a valid/ready response.

## Interface
- `NUM_BRAMS`, default 4: BRAM replicas. Each replica has 2 read ports, for `NUM_BRAMS*2` read lanes; writes are broadcast to all replicas.
- `DATA_W`, default 32: register width.
- `ADDR_W`, default 6: register index width.
- `clk` input 1: clock. All state changes on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `req_valid` input 1: a batch is offered.
- `req_ready` output 1: the block can accept a batch.
- `req_r_mask` input 12: read requests. `req_r_addr` input 12×`ADDR_W`.
- `req_w_mask` input 6: write requests. `req_w_addr` input 6×`ADDR_W`. `req_w_data` input 6×`DATA_W`.
- `r_read_mask` output 12 and `r_done_mask` output 12: to the selector.
- `w_read_mask` output 6 and `w_done_mask` output 6: to the selector.
- `r_selected_id` input `NUM_BRAMS*2`×4, and `w_selected_id` input 2×3: from the selector.
- `bram_rd_en` output `NUM_BRAMS*2`. `bram_rd_addr` output `NUM_BRAMS*2`×`ADDR_W`. `bram_rd_data` input `NUM_BRAMS*2`×`DATA_W`. Read latency is 1 cycle. Lane k maps to replica k/2, port k%2.
- `bram_wr_en` output 2. `bram_wr_addr` output 2×`ADDR_W`. `bram_wr_data` output 2×`DATA_W`.
- `rsp_valid` output 1. `rsp_ready` input 1. `rsp_r_data` output 12×`DATA_W`.

## Operation
- **FSM states:** IDLE, READ, WRITE, RESP.
- **Reset:** state=IDLE and all registers are zero. Every output is 0 except `req_ready`, which is 1.
- **IDLE:**
  - `req_ready=1`. All selector masks are 0.
  - On `req_valid`, latch the addresses, data and masks, and clear both done masks.
  - Next state is READ if the latched read mask is non-zero, else WRITE.
- **Pending counts:**
  - Read pending = `r_read_mask & ~r_done_mask`. Read lane n is used iff n < popcount(read pending). Used lanes carry distinct, ascending IDs from the selector.
  - Writes follow the same rule with lanes 0..1.
- **READ:**
  - Each used lane k asserts `bram_rd_en[k]` with the address of `r_selected_id[k]`.
  - The issued IDs are set in `r_done_mask` at the edge.
  - The ID and enable per lane are pipelined one cycle. In the following cycle, `bram_rd_data[k]` is written into response slot ID.
  - When read pending becomes 0 after the edge, go to WRITE.
- **WRITE:**
  - Each used lane j asserts `bram_wr_en[j]` with the address and data of `w_selected_id[j]`, and sets that bit in `w_done_mask`.
  - The state lasts max(1, ceil(writes/2)) cycles. This guarantees the final read-data capture before RESP.
  - Same-address writes in one cycle: lane 0 is suppressed, so the higher ID wins.
- **Ordering:** all reads of a batch observe pre-batch register values (read-before-write).
- **RESP:**
  - `rsp_valid=1`.
  - Slots whose `req_r_mask` bit is clear return 0.
  - Data is held stable until `rsp_ready`, then go to IDLE.
  - `req_ready=1` only in IDLE, so batches do not overlap.
- **Empty batch** (both masks 0): IDLE→WRITE (1 idle cycle)→RESP with all-zero data.
- **Reset mid-batch:** the batch is discarded, no further BRAM enables are issued, and the block returns to the reset values above.

## Timing
- Accept at cycle 0, with R=ceil(reads/(2·NUM_BRAMS)) and W=max(1, ceil(writes/2)):
  - READ occupies cycles 1..R.
  - WRITE occupies R+1..R+W.
  - `rsp_valid` rises in cycle R+W+1.
- Read data for an issue in cycle t is captured at the end of cycle t+1.
- The selector is combinational. Its masks are registered outputs of this block, so there is no loop.

## Configuration
- `RF_SEQ_X0_EN` defined:
  - Register index 0 is hardwired zero.
  - At accept, read requests to address 0 are pre-set in `r_done_mask` and return 0 without a BRAM read.
  - Writes to address 0 are pre-set in `w_done_mask` and never issued.
- Undefined: address 0 is an ordinary register.

## Test plan
- **Full batch:** NUM_BRAMS=4, 12 reads, 3 writes, `rsp_ready=1`. Expect 8 read enables in cycle 1 and 4 in cycle 2, writes of 2 then 1, and `rsp_valid` in cycle 5 with each slot equal to its BRAM preload.
- **Read-before-write:** read r5 and write r5=0xDEAD in the same batch. Expect `rsp_r_data` to hold the old r5. A following batch reads 0xDEAD.
- **Sparse mask:** `req_r_mask`=0x801, no writes. Expect lanes 0/1 issuing IDs 0/11 in cycle 1, WRITE idling in cycle 2, `rsp_valid` in cycle 3, and the other slots = 0.
- **Backpressure:** hold `rsp_ready=0` for 5 cycles. Expect `rsp_valid` and data stable, `req_ready=0`, then IDLE one cycle after the handshake.
- **Reset mid-operation:** assert `reset` low in cycle 1 of a 12-read batch. Expect all enables to drop immediately and `req_ready=1` after release.
- **`RF_SEQ_X0_EN`:** read r0 plus write r0=7. Expect no BRAM enables and slot data 0; without the macro, a BRAM read of address 0 is issued.
